iobuf_bus_ctrl: RTL and testbench
=================================

Name: iobuf_bus_ctrl

Overview:
- Sequences a shared bidirectional external data bus built from per-bit tri-state I/O buffers: output enable, pad data out, pad data in.
- Serves one write requester and one read requester with alternating-priority arbitration.
- Generates active-low write and read strobes, and enforces a high-Z turnaround gap after every transaction so the FPGA and the external device never drive the bus together.
- Sits between the processor's port logic and the I/O buffer instances.

Parameters:
- DATA_WIDTH, 8, bus width in bits.
- WR_HOLD, 2, cycles pad_we_n is held low (>=1).
- RD_WAIT, 2, cycles pad_oe_n is held low before sampling (>=1).
- TURN_CYCLES, 1, high-Z turnaround cycles after each transaction (>=1).

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- wr_req  in  1  write request level; held until wr_ack.
- wr_data  in  DATA_WIDTH  write data; captured at acceptance.
- wr_ack  out  1  one-cycle pulse: write complete.
- rd_req  in  1  read request level; held until rd_ack.
- rd_data  out  DATA_WIDTH  registered read data; valid from rd_ack, held until next read ack.
- rd_ack  out  1  one-cycle pulse: read complete.
- busy  out  1  high whenever state != IDLE.
- pad_t  out  1  tri-state control to every buffer bit T; 1 = high-Z.
- pad_o  out  DATA_WIDTH  data to buffer I inputs.
- pad_i  in  DATA_WIDTH  data from buffer O outputs.
- pad_we_n  out  1  external write strobe, active low.
- pad_oe_n  out  1  external output-enable/read strobe, active low.

Behaviour:
- All outputs registered. Reset values: state=IDLE, pad_t=1, pad_o=0, pad_we_n=1, pad_oe_n=1, wr_ack=0, rd_ack=0, rd_data=0, busy=0, last_served=READ.
- Reset asserted mid-transaction overrides everything at the next edge: bus released, strobes deasserted, no ack issued, transaction lost.
- States: IDLE, WR_SETUP, WR_STROBE, WR_RELEASE, RD_STROBE, TURN.
- IDLE: pad_t=1, both strobes high. Requests are sampled only here.
  - Only wr_req -> accept write.
  - Only rd_req -> accept read.
  - Both -> grant the type opposite last_served, then update last_served.
  - Acceptance captures wr_data into the output register.
- Write timing (acceptance = cycle 0):
  - Cycle 1, WR_SETUP: pad_t=0, pad_o=data, pad_we_n=1.
  - Cycles 2..1+WR_HOLD, WR_STROBE: pad_we_n=0.
  - Cycle 2+WR_HOLD, WR_RELEASE: pad_we_n=1, pad_t still 0, data held.
  - Then TURN.
- Read timing (acceptance = cycle 0):
  - Cycles 1..RD_WAIT, RD_STROBE: pad_t=1, pad_oe_n=0.
  - On the edge ending the last RD_STROBE cycle, pad_i is captured into rd_data.
  - Then TURN.
- TURN: pad_t=1, both strobes high, lasts TURN_CYCLES cycles.
  - Ack (wr_ack or rd_ack per transaction type) is high in the first TURN cycle only.
  - After TURN, return to IDLE.
- pad_t is never 0 while pad_oe_n=0. pad_t 0->1 and pad_oe_n 1->0 transitions are separated by at least TURN_CYCLES high-Z cycles across transactions.
- Requester must drop its req within TURN_CYCLES cycles after ack. A req still high in IDLE is a new request.
- Requests deasserted after acceptance do not abort the transaction.
- Write latency to ack: 3+WR_HOLD cycles; back in IDLE at 3+WR_HOLD+TURN_CYCLES.
- Read latency to ack: 1+RD_WAIT cycles; back in IDLE at 1+RD_WAIT+TURN_CYCLES.
- pad_o retains the last written value when released; it is don't-care under pad_t=1.

Test Plan:
- Reset check: assert reset 3 cycles -> pad_t=1, pad_we_n=1, pad_oe_n=1, busy=0, rd_data=0x00.
- Single write (defaults), wr_data=0xA5 at cycle 0:
  - pad_t=0 cycles 1-4, pad_o=0xA5.
  - pad_we_n=0 cycles 2-3.
  - wr_ack pulses cycle 5; busy low cycle 6.
- Single read, pad_i=0x3C:
  - pad_oe_n=0 cycles 1-2, pad_t=1 throughout.
  - rd_ack and rd_data=0x3C at cycle 3; IDLE cycle 4.
  - Changing pad_i to 0xFF after cycle 2 leaves rd_data=0x3C.
- Simultaneous requests held continuously from reset: grants alternate write, read, write, read.
  - A 1-cycle pad_t=1 gap precedes every pad_oe_n low.
  - pad_t never 0 while pad_oe_n=0 (assertion).
- Reset mid-write: reset in WR_STROBE -> next cycle pad_t=1, pad_we_n=1, no wr_ack; a subsequent write with 0x5A completes normally.
- Parameter sweep WR_HOLD=1, RD_WAIT=4, TURN_CYCLES=3: strobe widths 1 and 4 cycles, TURN lasts 3 cycles, ack latencies 4 and 5.

Source files
------------

// File: rtl/iobuf_bus_ctrl.sv
// Sequences a shared tri-state data bus for one write and one read requester,
// generating active-low strobes and a high-Z turnaround gap after every transfer.
module iobuf_bus_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int WR_HOLD     = 2,
  parameter int RD_WAIT     = 2,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_ack,
  output logic                  busy,
  output logic                  pad_t,
  output logic [DATA_WIDTH-1:0] pad_o,
  input  logic [DATA_WIDTH-1:0] pad_i,
  output logic                  pad_we_n,
  output logic                  pad_oe_n
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_SETUP   = 3'd1;
  localparam logic [2:0] WR_STROBE  = 3'd2;
  localparam logic [2:0] WR_RELEASE = 3'd3;
  localparam logic [2:0] RD_STROBE  = 3'd4;
  localparam logic [2:0] TURN       = 3'd5;

  localparam int MAX_WR = (WR_HOLD > RD_WAIT) ? WR_HOLD : RD_WAIT;
  localparam int MAX_P  = (MAX_WR > TURN_CYCLES) ? MAX_WR : TURN_CYCLES;
  localparam int CW     = $clog2(MAX_P + 1);

  logic [2:0]    state;
  logic [2:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic          last_rd;
  logic          grant_wr;
  logic          grant_rd;

  // Valid/ready style: a request level is only looked at in IDLE; the
  // matching one-cycle ack in the first TURN cycle completes the handshake.
  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_req && (!rd_req || last_rd)) begin
          state_nxt = WR_SETUP;
          grant_wr  = 1'b1;
        end else if (rd_req) begin
          state_nxt = RD_STROBE;
          grant_rd  = 1'b1;
        end
      end
      WR_SETUP:   state_nxt = WR_STROBE;
      WR_STROBE:  if (cnt == CW'(WR_HOLD - 1)) state_nxt = WR_RELEASE;
      WR_RELEASE: state_nxt = TURN;
      RD_STROBE:  if (cnt == CW'(RD_WAIT - 1)) state_nxt = TURN;
      TURN:       if (cnt == CW'(TURN_CYCLES - 1)) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Pad controls are decoded from the next state so they are registered
  // yet line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      last_rd  <= 1'b1;
      pad_t    <= 1'b1;
      pad_o    <= '0;
      pad_we_n <= 1'b1;
      pad_oe_n <= 1'b1;
      wr_ack   <= 1'b0;
      rd_ack   <= 1'b0;
      rd_data  <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= (state_nxt != state) ? '0 : cnt + CW'(1);
      if (grant_wr) begin
        last_rd <= 1'b0;
        pad_o   <= wr_data;
      end
      if (grant_rd) last_rd <= 1'b1;
      pad_t    <= !(state_nxt == WR_SETUP || state_nxt == WR_STROBE ||
                    state_nxt == WR_RELEASE);
      pad_we_n <= (state_nxt != WR_STROBE);
      pad_oe_n <= (state_nxt != RD_STROBE);
      busy     <= (state_nxt != IDLE);
      wr_ack   <= (state == WR_RELEASE);
      rd_ack   <= (state == RD_STROBE) && (state_nxt == TURN);
      if ((state == RD_STROBE) && (state_nxt == TURN)) rd_data <= pad_i;
    end
  end

endmodule

// File: tb/tb_iobuf_bus_ctrl.sv
// Bench for iobuf_bus_ctrl: a default instance and a parameter-sweep instance,
// both checked every cycle against a transaction-timing reference model.
module tb_iobuf_bus_ctrl;

  localparam int DW  = 8;
  localparam int WH0 = 2, RW0 = 2, TC0 = 1;
  localparam int WH1 = 1, RW1 = 4, TC1 = 3;

  logic          clk;
  logic          reset    [2];
  logic          wr_req   [2];
  logic [DW-1:0] wr_data  [2];
  logic          wr_ack   [2];
  logic          rd_req   [2];
  logic [DW-1:0] rd_data  [2];
  logic          rd_ack   [2];
  logic          busy     [2];
  logic          pad_t    [2];
  logic [DW-1:0] pad_o    [2];
  logic [DW-1:0] pad_i    [2];
  logic          pad_we_n [2];
  logic          pad_oe_n [2];

  iobuf_bus_ctrl #(.DATA_WIDTH(DW), .WR_HOLD(WH0), .RD_WAIT(RW0), .TURN_CYCLES(TC0)) u0 (
    .clk(clk), .reset(reset[0]), .wr_req(wr_req[0]), .wr_data(wr_data[0]),
    .wr_ack(wr_ack[0]), .rd_req(rd_req[0]), .rd_data(rd_data[0]), .rd_ack(rd_ack[0]),
    .busy(busy[0]), .pad_t(pad_t[0]), .pad_o(pad_o[0]), .pad_i(pad_i[0]),
    .pad_we_n(pad_we_n[0]), .pad_oe_n(pad_oe_n[0])
  );

  iobuf_bus_ctrl #(.DATA_WIDTH(DW), .WR_HOLD(WH1), .RD_WAIT(RW1), .TURN_CYCLES(TC1)) u1 (
    .clk(clk), .reset(reset[1]), .wr_req(wr_req[1]), .wr_data(wr_data[1]),
    .wr_ack(wr_ack[1]), .rd_req(rd_req[1]), .rd_data(rd_data[1]), .rd_ack(rd_ack[1]),
    .busy(busy[1]), .pad_t(pad_t[1]), .pad_o(pad_o[1]), .pad_i(pad_i[1]),
    .pad_we_n(pad_we_n[1]), .pad_oe_n(pad_oe_n[1])
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  bit auto_en [2];

  // reference model: one record per instance describing the transaction in flight
  bit            m_act     [2];
  bit            m_rd      [2];
  int            m_t0      [2];
  bit            m_last_rd [2];
  logic [DW-1:0] m_rdd     [2];
  logic [DW-1:0] m_po      [2];
  int            hz        [2];
  logic          prev_oe   [2];

  function automatic int wh(input int i); return (i == 0) ? WH0 : WH1; endfunction
  function automatic int rw(input int i); return (i == 0) ? RW0 : RW1; endfunction
  function automatic int tc(input int i); return (i == 0) ? TC0 : TC1; endfunction
  function automatic int dur(input int i, input bit rd);
    return rd ? (1 + rw(i) + tc(i)) : (3 + wh(i) + tc(i));
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advances the model over the cycle that is ending at this edge.
  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (reset[i]) begin
        m_act[i] = 1'b0;
        m_last_rd[i] = 1'b1;
        m_rdd[i] = '0;
        m_po[i] = '0;
      end else begin
        if (m_act[i] && cyc >= m_t0[i] + dur(i, m_rd[i])) m_act[i] = 1'b0;
        if (m_act[i]) begin
          if (m_rd[i] && cyc == m_t0[i] + rw(i)) m_rdd[i] = pad_i[i];
        end else if (wr_req[i] || rd_req[i]) begin
          m_rd[i] = rd_req[i] && (!wr_req[i] || !m_last_rd[i]);
          m_act[i] = 1'b1;
          m_t0[i] = cyc;
          m_last_rd[i] = m_rd[i];
          if (!m_rd[i]) m_po[i] = wr_data[i];
        end
      end
    end
    cyc++;
  endtask

  task automatic compare_outputs();
    for (int i = 0; i < 2; i++) begin
      logic e_t, e_we, e_oe, e_wa, e_ra, e_busy;
      int r;
      string p;
      p = $sformatf("u%0d.", i);
      e_t = 1'b1; e_we = 1'b1; e_oe = 1'b1; e_wa = 1'b0; e_ra = 1'b0; e_busy = 1'b0;
      r = cyc - m_t0[i];
      if (m_act[i] && r < dur(i, m_rd[i])) begin
        e_busy = 1'b1;
        if (!m_rd[i]) begin
          e_t  = !(r >= 1 && r <= 2 + wh(i));
          e_we = !(r >= 2 && r <= 1 + wh(i));
          e_wa = (r == 3 + wh(i));
        end else begin
          e_oe = !(r >= 1 && r <= rw(i));
          e_ra = (r == 1 + rw(i));
        end
      end
      check({p, "pad_t"}, pad_t[i], e_t);
      check({p, "pad_we_n"}, pad_we_n[i], e_we);
      check({p, "pad_oe_n"}, pad_oe_n[i], e_oe);
      check({p, "wr_ack"}, wr_ack[i], e_wa);
      check({p, "rd_ack"}, rd_ack[i], e_ra);
      check({p, "busy"}, busy[i], e_busy);
      check({p, "pad_o"}, pad_o[i], m_po[i]);
      check({p, "rd_data"}, rd_data[i], m_rdd[i]);
      check({p, "overlap"}, (!pad_t[i] && !pad_oe_n[i]), 1'b0);
      if (prev_oe[i] === 1'b1 && pad_oe_n[i] === 1'b0)
        check({p, "turn_gap"}, (hz[i] >= tc(i)), 1'b1);
      prev_oe[i] = pad_oe_n[i];
      hz[i] = (pad_t[i] === 1'b1) ? hz[i] + 1 : 0;
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (chk_en) compare_outputs();
  endtask

  task automatic drive_auto();
    for (int i = 0; i < 2; i++) begin
      if (auto_en[i]) begin
        pad_i[i] = DW'($urandom);
        reset[i] = ($urandom_range(0, 299) == 0);
        if (wr_req[i] && wr_ack[i]) wr_req[i] = 1'b0;
        else if (!wr_req[i] && $urandom_range(0, 3) == 0) begin
          wr_req[i] = 1'b1;
          wr_data[i] = DW'($urandom);
        end
        if (rd_req[i] && rd_ack[i]) rd_req[i] = 1'b0;
        else if (!rd_req[i] && $urandom_range(0, 3) == 0) rd_req[i] = 1'b1;
      end
    end
  endtask

  task automatic wait_idle(input int i);
    int n;
    n = 0;
    while (busy[i] !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    check($sformatf("u%0d.idle_timeout", i), (n < 50), 1'b1);
  endtask

  // Issues one request from IDLE and measures ack latency, strobe width and TURN length.
  task automatic single_txn(input int i, input bit is_rd, input logic [DW-1:0] d,
                            input int lat, input int strb, input int turn);
    int ack_at, idle_at, sw;
    string p;
    ack_at = -1; idle_at = -1; sw = 0;
    p = $sformatf("u%0d.%s", i, is_rd ? "rd" : "wr");
    if (is_rd) begin
      pad_i[i] = d;
      rd_req[i] = 1'b1;
    end else begin
      wr_data[i] = d;
      wr_req[i] = 1'b1;
    end
    for (int n = 1; n <= 64 && idle_at < 0; n++) begin
      tick();
      if (is_rd && n == lat) pad_i[i] = 8'hFF;
      if (wr_ack[i] || rd_ack[i]) begin
        ack_at = n;
        wr_req[i] = 1'b0;
        rd_req[i] = 1'b0;
        if (is_rd) check({p, "_data"}, rd_data[i], d);
      end
      if (!(is_rd ? pad_oe_n[i] : pad_we_n[i])) sw++;
      if (ack_at >= 0 && !busy[i]) idle_at = n;
    end
    check({p, "_latency"}, ack_at, lat);
    check({p, "_strobe"}, sw, strb);
    check({p, "_turn"}, idle_at - ack_at, turn);
  endtask

  // scoreboard for the alternating-grant sequence
  logic [1:0] exp_q [$];

  initial begin
    int acks;
    for (int i = 0; i < 2; i++) begin
      reset[i] = 1'b1; wr_req[i] = 1'b0; rd_req[i] = 1'b0;
      wr_data[i] = '0; pad_i[i] = '0; auto_en[i] = 1'b0;
      m_act[i] = 1'b0; m_rd[i] = 1'b0; m_t0[i] = 0; m_last_rd[i] = 1'b1;
      m_rdd[i] = '0; m_po[i] = '0; hz[i] = 100; prev_oe[i] = 1'b1;
    end
    tick();
    chk_en = 1'b1;
    tick();
    tick();
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    tick();

    single_txn(0, 1'b0, 8'hA5, 3 + WH0, WH0, TC0);
    wait_idle(0);
    single_txn(0, 1'b1, 8'h3C, 1 + RW0, RW0, TC0);
    wait_idle(0);

    // both requests held from reset: write, read, write, read
    reset[0] = 1'b1;
    wr_req[0] = 1'b1; rd_req[0] = 1'b1; wr_data[0] = 8'h69;
    repeat (3) tick();
    reset[0] = 1'b0;
    exp_q = '{2'd1, 2'd2, 2'd1, 2'd2};
    acks = 0;
    for (int n = 0; n < 80 && acks < 4; n++) begin
      tick();
      if (wr_ack[0] || rd_ack[0]) begin
        check("u0.grant_order", {rd_ack[0], wr_ack[0]}, exp_q.pop_front());
        acks++;
      end
    end
    check("u0.grant_count", acks, 4);
    wr_req[0] = 1'b0; rd_req[0] = 1'b0;
    wait_idle(0);

    // reset during WR_STROBE drops the transfer
    wr_data[0] = 8'hC3; wr_req[0] = 1'b1;
    tick();
    tick();
    reset[0] = 1'b1; wr_req[0] = 1'b0;
    tick();
    reset[0] = 1'b0;
    check("u0.rst_pad_t", pad_t[0], 1'b1);
    check("u0.rst_we_n", pad_we_n[0], 1'b1);
    acks = 0;
    repeat (6) begin
      tick();
      if (wr_ack[0]) acks++;
    end
    check("u0.rst_no_ack", acks, 0);
    single_txn(0, 1'b0, 8'h5A, 3 + WH0, WH0, TC0);
    wait_idle(0);

    single_txn(1, 1'b0, 8'h96, 3 + WH1, WH1, TC1);
    wait_idle(1);
    single_txn(1, 1'b1, 8'h4B, 1 + RW1, RW1, TC1);
    wait_idle(1);

    auto_en[0] = 1'b1;
    auto_en[1] = 1'b1;
    repeat (2500) begin
      tick();
      drive_auto();
    end
    for (int i = 0; i < 2; i++) begin
      auto_en[i] = 1'b0; reset[i] = 1'b0; wr_req[i] = 1'b0; rd_req[i] = 1'b0;
    end
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
